// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
package spi_cfg_pkg;

    localparam int DEF_WORD_W = 24;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        MODE_SEQ    = 1'b0,
        MODE_SINGLE = 1'b1
    } mode_t;

    // Power-up register words for the ADRF-class modulator; the host writes
    // these into the table through the table write port.
    localparam int ADRF_INIT_LEN = 4;
    localparam logic [DEF_WORD_W-1:0] ADRF_INIT_TBL [ADRF_INIT_LEN] = '{
        24'h02F67F, 24'h04081A, 24'h66141E, 24'h0F0A55
    };

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Host-side and SPI-side signal bundle of the configuration sequencer.
interface spi_cfg_sequencer_if #(
    parameter int WORD_W = spi_cfg_pkg::DEF_WORD_W,
    parameter int DEPTH  = spi_cfg_pkg::DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic              start;
    logic              enable;
    logic [AW:0]       seq_len;
    logic              tbl_we;
    logic [AW-1:0]     tbl_addr;
    logic [WORD_W-1:0] tbl_wdata;
    logic              wr_req;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ack;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              busy;
    logic              done;
    logic [AW-1:0]     word_idx;

    modport master (
        output start, enable, seq_len, tbl_we, tbl_addr, tbl_wdata, wr_req, wr_data,
        input  wr_ack, spi_sclk, spi_cs_n, spi_mosi, busy, done, word_idx
    );

    modport slave (
        input  start, enable, seq_len, tbl_we, tbl_addr, tbl_wdata, wr_req, wr_data,
        output wr_ack, spi_sclk, spi_cs_n, spi_mosi, busy, done, word_idx
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// MSB-first SPI mode-0 serializer. sclk and mosi are registered and always
// show the value for the cycle that follows the current edge.
module spi_tx_shifter #(
    parameter int WORD_W  = 24,
    parameter int CLK_DIV = 2
) (
    input  logic              GCLK,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [WORD_W-1:0] data,
    output logic              sclk,
    output logic              mosi,
    output logic              last_bit
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = $clog2(WORD_W);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_r;
    logic [PW-1:0]     phase_r;
    logic [BW-1:0]     bit_r;
    logic              sclk_r;
    logic              mosi_r;

    assign last_bit = (bit_r == BIT_LAST) && (phase_r == PH_LAST);
    assign sclk     = sclk_r;
    assign mosi     = mosi_r;

    // Shift register, phase and bit counters; everything holds when neither load nor en.
    always_ff @(posedge GCLK) begin
        if (reset) begin
            shreg_r <= '0;
            phase_r <= '0;
            bit_r   <= '0;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
        end else if (load) begin
            shreg_r <= data;
            phase_r <= '0;
            bit_r   <= '0;
            sclk_r  <= 1'b0;
            mosi_r  <= data[WORD_W-1];
        end else if (en) begin
            if (phase_r == PH_LAST) begin
                phase_r <= '0;
                sclk_r  <= 1'b0;
                shreg_r <= {shreg_r[WORD_W-2:0], 1'b0};
                if (bit_r == BIT_LAST) begin
                    bit_r  <= '0;
                    mosi_r <= 1'b0;
                end else begin
                    bit_r  <= bit_r + BW'(1);
                    mosi_r <= shreg_r[WORD_W-2];
                end
            end else begin
                phase_r <= phase_r + PW'(1);
                sclk_r  <= ((phase_r + PW'(1)) >= PH_HALF);
            end
        end
    end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Table-driven SPI register-init sequencer with a one-shot single-word write path.
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic GCLK,
    input  logic reset,
    spi_cfg_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    logic [WORD_W-1:0] tbl_r [DEPTH];

    state_t            state_r, state_nx, ret_r;
    mode_t             mode_r;
    logic [AW-1:0]     word_idx_r;
    logic [LW-1:0]     len_r;
    logic [GW-1:0]     gap_cnt_r;
    logic              busy_r, done_r, cs_n_r, wr_ack_r;
    logic              busy_nx, done_nx, cs_n_nx, wr_ack_nx;

    logic [LW-1:0]     eff_len_s;
    logic              idle_s, start_ok_s, wr_ok_s, gap_last_s, gap_exit_s, last_word_s;
    logic              shift_last_s, sclk_s, mosi_s;
    logic [WORD_W-1:0] load_data_s;

    assign eff_len_s   = (bus.seq_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.seq_len;
    assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign start_ok_s  = idle_s && bus.enable && bus.start;
    // The cycle carrying wr_ack still sees the old wr_req level; ignore it there.
    assign wr_ok_s     = idle_s && bus.enable && !bus.start && bus.wr_req && !wr_ack_r;
    assign gap_last_s  = (gap_cnt_r == GAP_LAST);
    assign gap_exit_s  = (state_r == ST_GAP) && bus.enable && gap_last_s;
    assign last_word_s = (({1'b0, word_idx_r} + LW'(1)) == len_r);
    assign load_data_s = (mode_r == MODE_SINGLE) ? bus.wr_data : tbl_r[word_idx_r];

    spi_tx_shifter #(.WORD_W(WORD_W), .CLK_DIV(CLK_DIV)) u_shifter (
        .GCLK     (GCLK),
        .reset    (reset),
        .load     ((state_r == ST_LOAD) && bus.enable),
        .en       ((state_r == ST_SHIFT) && bus.enable),
        .data     (load_data_s),
        .sclk     (sclk_s),
        .mosi     (mosi_s),
        .last_bit (shift_last_s)
    );

    // Table RAM; a write on the same edge as a LOAD read leaves LOAD with the old word.
    always_ff @(posedge GCLK) begin
        if (bus.tbl_we) begin
            tbl_r[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge GCLK) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic; enable low freezes every state.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_nx = (eff_len_s == '0) ? ST_DONE : ST_LOAD;
                end else if (wr_ok_s) begin
                    state_nx = ST_LOAD;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_LOAD: begin
                if (bus.enable) begin
                    state_nx = ST_SHIFT;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_SHIFT: begin
                if (bus.enable && shift_last_s) begin
                    state_nx = ST_GAP;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_GAP: begin
                if (!gap_exit_s) begin
                    state_nx = state_r;
                end else if (mode_r == MODE_SINGLE) begin
                    state_nx = ret_r;
                end else if (last_word_s) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status and chip select.
    always_comb begin
        busy_nx   = (state_nx == ST_LOAD) || (state_nx == ST_SHIFT) || (state_nx == ST_GAP);
        cs_n_nx   = (state_nx != ST_SHIFT);
        wr_ack_nx = gap_exit_s && (mode_r == MODE_SINGLE);
        if (start_ok_s) begin
            done_nx = (eff_len_s == '0);
        end else if (gap_exit_s && (mode_r == MODE_SEQ) && last_word_s) begin
            done_nx = 1'b1;
        end else begin
            done_nx = done_r;
        end
    end

    // Registered handshake and chip-select outputs.
    always_ff @(posedge GCLK) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cs_n_r   <= 1'b1;
            wr_ack_r <= 1'b0;
        end else begin
            busy_r   <= busy_nx;
            done_r   <= done_nx;
            cs_n_r   <= cs_n_nx;
            wr_ack_r <= wr_ack_nx;
        end
    end

    // Run context: mode, return state, latched length and word index.
    always_ff @(posedge GCLK) begin
        if (reset) begin
            mode_r     <= MODE_SEQ;
            ret_r      <= ST_IDLE;
            len_r      <= '0;
            word_idx_r <= '0;
        end else if (start_ok_s) begin
            mode_r     <= MODE_SEQ;
            len_r      <= eff_len_s;
            word_idx_r <= '0;
        end else if (wr_ok_s) begin
            mode_r     <= MODE_SINGLE;
            ret_r      <= state_r;
        end else if (gap_exit_s && (mode_r == MODE_SEQ) && !last_word_s) begin
            word_idx_r <= word_idx_r + AW'(1);
        end
    end

    // CS-high gap counter, cleared whenever the FSM is outside GAP.
    always_ff @(posedge GCLK) begin
        if (reset || (state_r != ST_GAP)) begin
            gap_cnt_r <= '0;
        end else if (bus.enable) begin
            gap_cnt_r <= gap_last_s ? '0 : (gap_cnt_r + GW'(1));
        end
    end

    assign bus.spi_sclk = sclk_s;
    assign bus.spi_mosi = mosi_s;
    assign bus.spi_cs_n = cs_n_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.wr_ack   = wr_ack_r;
    assign bus.word_idx = word_idx_r;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer: table vectors, corner-case
// sequences and randomized runs against a word-level reference model.
module tb_spi_cfg_sequencer;
    import spi_cfg_pkg::*;

    localparam int WORD_W   = 24;
    localparam int DEPTH    = 32;
    localparam int AW       = 5;
    localparam int CLK_DIV  = 2;
    localparam int CS_GAP   = 2;
    localparam int WORD_CYC = 1 + WORD_W * CLK_DIV + CS_GAP;
    localparam int FRAME    = WORD_W * CLK_DIV;

    logic GCLK  = 1'b0;
    logic reset = 1'b1;
    always #5 GCLK = ~GCLK;

    spi_cfg_sequencer_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus();

    spi_cfg_sequencer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .GCLK  (GCLK),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: the table contents as the host has written them.
    logic [WORD_W-1:0] tbl_m [DEPTH];

    // SPI bus monitor state.
    logic [WORD_W-1:0] word_q [$];
    int                nbit_q [$];
    int                low_q  [$];
    logic [WORD_W-1:0] cap      = '0;
    int                nbits    = 0;
    int                low_cnt  = 0;
    int                mosi_bad = 0;
    logic              prev_cs   = 1'b1;
    logic              prev_sclk = 1'b0;
    logic              prev_mosi = 1'b0;

    typedef struct {
        int seq_len;
        int exp_frames;
        int exp_cycles;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge GCLK);
        #1;
    endtask

    task automatic clear_mon();
        word_q.delete();
        nbit_q.delete();
        low_q.delete();
    endtask

    task automatic tbl_write(input int idx, input logic [WORD_W-1:0] d);
        logic [31:0] iv;
        iv = idx;
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = iv[AW-1:0];
        bus.tbl_wdata = d;
        step();
        bus.tbl_we = 1'b0;
        tbl_m[idx] = d;
    endtask

    // Start a table run; cycles counts edges from the start edge (1) to done.
    task automatic run_seq(input int len, input int pause_pct,
                           output int cycles, output int paused, output logic busy1);
        logic [31:0] lv;
        lv = len;
        clear_mon();
        bus.seq_len = lv[AW:0];
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        busy1  = bus.busy;
        cycles = 1;
        paused = 0;
        while (!bus.done && cycles < 4000) begin
            bus.enable = ($urandom_range(0, 99) < pause_pct) ? 1'b0 : 1'b1;
            if (!bus.enable) paused++;
            step();
            cycles++;
        end
        bus.enable = 1'b1;
    endtask

    // Capture words on sclk rise inside each CS-low window.
    always @(negedge GCLK) begin
        prev_cs   <= bus.spi_cs_n;
        prev_sclk <= bus.spi_sclk;
        prev_mosi <= bus.spi_mosi;
        if (!bus.spi_cs_n) begin
            low_cnt <= low_cnt + 1;
            if (bus.spi_sclk && !prev_sclk) begin
                cap   <= {cap[WORD_W-2:0], bus.spi_mosi};
                nbits <= nbits + 1;
            end
            if (bus.spi_sclk && !prev_cs && (bus.spi_mosi !== prev_mosi)) mosi_bad <= mosi_bad + 1;
        end else begin
            if (!prev_cs) begin
                word_q.push_back(cap);
                nbit_q.push_back(nbits);
                low_q.push_back(low_cnt);
            end
            low_cnt <= 0;
            cap     <= '0;
            nbits   <= 0;
        end
    end

    initial begin
        int cyc, paused, k, len, nf;
        logic b1, frozen_ok, premature;
        logic [2:0] snap;

        // Expected cycles: done edge counted from start edge = 1 + N*WORD_CYC (N clamped to DEPTH).
        vecs[0] = '{seq_len: 0,  exp_frames: 0,  exp_cycles: 1};
        vecs[1] = '{seq_len: 2,  exp_frames: 2,  exp_cycles: 103};
        vecs[2] = '{seq_len: 1,  exp_frames: 1,  exp_cycles: 52};
        vecs[3] = '{seq_len: 3,  exp_frames: 3,  exp_cycles: 154};
        vecs[4] = '{seq_len: 40, exp_frames: 32, exp_cycles: 1633};

        bus.start = 1'b0; bus.enable = 1'b1; bus.seq_len = '0;
        bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_wdata = '0;
        bus.wr_req = 1'b0; bus.wr_data = '0;

        repeat (3) step();
        check("rst_cs_n",   bus.spi_cs_n, 1);
        check("rst_sclk",   bus.spi_sclk, 0);
        check("rst_mosi",   bus.spi_mosi, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.done, 0);
        check("rst_wr_ack", bus.wr_ack, 0);
        check("rst_idx",    bus.word_idx, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < DEPTH; i++) begin
            if (i < ADRF_INIT_LEN) tbl_write(i, ADRF_INIT_TBL[i]);
            else tbl_write(i, {i[7:0], 16'hC35A ^ i[15:0]});
        end

        // Table-driven runs.
        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].seq_len, 0, cyc, paused, b1);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cycles);
            check($sformatf("v%0d_frames", v), word_q.size(), vecs[v].exp_frames);
            check($sformatf("v%0d_busy", v), b1, (vecs[v].exp_frames > 0) ? 1 : 0);
            check($sformatf("v%0d_idx", v), bus.word_idx,
                  (vecs[v].exp_frames > 0) ? vecs[v].exp_frames - 1 : 0);
            for (int i = 0; i < word_q.size() && i < vecs[v].exp_frames; i++) begin
                check($sformatf("v%0d_word%0d", v, i), word_q[i], tbl_m[i]);
                check($sformatf("v%0d_bits%0d", v, i), nbit_q[i], WORD_W);
                check($sformatf("v%0d_cslow%0d", v, i), low_q[i], FRAME);
            end
        end

        // Single-word write from DONE.
        clear_mon();
        bus.wr_data = 24'h66141E;
        bus.wr_req  = 1'b1;
        step();
        k = 0;
        while (!bus.wr_ack && k < 200) begin step(); k++; end
        check("single_ack_lat", k, WORD_CYC);
        bus.wr_req = 1'b0;
        check("single_done_kept", bus.done, 1);
        step();
        check("single_ack_pulse", bus.wr_ack, 0);
        check("single_frames", word_q.size(), 1);
        if (word_q.size() > 0) begin
            check("single_word", word_q[0], 24'h66141E);
            check("single_cslow", low_q[0], FRAME);
        end

        // Pause for 10 cycles at bit 7 of word 0.
        clear_mon();
        bus.seq_len = 6'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        repeat (15) begin step(); cyc++; end
        check("pause_in_shift", bus.spi_cs_n, 0);
        snap = {bus.spi_sclk, bus.spi_cs_n, bus.spi_mosi};
        bus.enable = 1'b0;
        frozen_ok = 1'b1;
        repeat (10) begin
            step(); cyc++;
            if ({bus.spi_sclk, bus.spi_cs_n, bus.spi_mosi} !== snap || !bus.busy) frozen_ok = 1'b0;
        end
        check("pause_frozen", frozen_ok, 1);
        bus.enable = 1'b1;
        while (!bus.done && cyc < 4000) begin step(); cyc++; end
        check("pause_cycles", cyc, 2 * WORD_CYC + 1 + 10);
        check("pause_frames", word_q.size(), 2);
        for (int i = 0; i < word_q.size() && i < 2; i++)
            check($sformatf("pause_word%0d", i), word_q[i], tbl_m[i]);

        // Table write during word 0 and a wr_req raised mid-run.
        clear_mon();
        bus.seq_len = 6'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        premature = 1'b0;
        repeat (9) begin step(); cyc++; end
        tbl_write(1, 24'hABCDEF);
        cyc++;
        bus.wr_data = 24'h123456;
        bus.wr_req  = 1'b1;
        bus.start   = 1'b1;
        while (!bus.done && cyc < 4000) begin
            step(); cyc++;
            if (bus.wr_ack && !bus.done) premature = 1'b1;
        end
        bus.start = 1'b0;
        check("tw_cycles", cyc, 2 * WORD_CYC + 1);
        check("tw_no_early_ack", premature, 0);
        k = 0;
        while (!bus.wr_ack && k < 200) begin step(); k++; end
        check("tw_ack_lat", k, WORD_CYC + 1);
        bus.wr_req = 1'b0;
        check("tw_done_kept", bus.done, 1);
        step();
        check("tw_frames", word_q.size(), 3);
        if (word_q.size() == 3) begin
            check("tw_word0", word_q[0], tbl_m[0]);
            check("tw_word1", word_q[1], 24'hABCDEF);
            check("tw_word2", word_q[2], 24'h123456);
        end

        // Reset at bit 12 of word 1, then a fresh run.
        clear_mon();
        bus.seq_len = 6'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (76) step();
        check("rr_in_word1", {bus.spi_cs_n, bus.word_idx}, {1'b0, 5'd1});
        reset = 1'b1;
        step();
        check("rr_cs_n", bus.spi_cs_n, 1);
        check("rr_sclk", bus.spi_sclk, 0);
        check("rr_mosi", bus.spi_mosi, 0);
        check("rr_busy", bus.busy, 0);
        check("rr_done", bus.done, 0);
        reset = 1'b0;
        step();
        run_seq(2, 0, cyc, paused, b1);
        check("rr_cycles", cyc, 2 * WORD_CYC + 1);
        check("rr_frames", word_q.size(), 2);
        for (int i = 0; i < word_q.size() && i < 2; i++)
            check($sformatf("rr_word%0d", i), word_q[i], tbl_m[i]);

        // Randomized runs with random table rewrites and pauses.
        for (int r = 0; r < 6; r++) begin
            repeat (2) tbl_write($urandom_range(0, 7), WORD_W'($urandom));
            len = $urandom_range(1, 7);
            run_seq(len, 10, cyc, paused, b1);
            check($sformatf("rnd%0d_cycles", r), cyc, 1 + len * WORD_CYC + paused);
            nf = word_q.size();
            check($sformatf("rnd%0d_frames", r), nf, len);
            for (int i = 0; i < nf && i < len; i++)
                check($sformatf("rnd%0d_word%0d", r, i), word_q[i], tbl_m[i]);
        end

        check("mosi_stable_sclk_high", mosi_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Parametrised successor to the fixed-table SPI register-init engine for the TX RF chips (ADRF-class modulators, PLLs).
- Streams a programmable table of WORD_W-bit register words out over 3-wire SPI (mode 0, MSB first). Each word is framed by its own CS low period, and words are separated by a programmable CS-high gap.
- Adds start/busy/done handshake, pause control, a host table-write port and a one-shot single-word write path for runtime retuning (e.g. LO-nulling trims) after init.

Parameters:
- WORD_W, 24, bits per SPI word.
- DEPTH, 32, table entries; AW = clog2(DEPTH).
- CLK_DIV, 2, GCLK cycles per SCLK period; even, >= 2.
- CS_GAP, 2, GCLK cycles CS held high in GAP between words; >= 1.

Ports:
- GCLK  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin table sequence; sampled in IDLE/DONE
- enable  in  1  0 = freeze all counters and outputs (pause)
- seq_len  in  AW+1  words to send, entries 0..seq_len-1; values > DEPTH clamp to DEPTH
- tbl_we  in  1  table write strobe
- tbl_addr  in  AW  table write address
- tbl_wdata  in  WORD_W  table write data
- wr_req  in  1  single-word write request; level, held until wr_ack
- wr_data  in  WORD_W  single-word data; must be stable while wr_req is high
- wr_ack  out  1  one-cycle pulse when the single word has completed, including its gap
- spi_sclk  out  1  SPI clock, idle low
- spi_cs_n  out  1  chip select, active low
- spi_mosi  out  1  serial data
- busy  out  1  high in LOAD/SHIFT/GAP
- done  out  1  sticky; table sequence finished
- word_idx  out  AW  index of the word in flight

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, wr_ack=0, word_idx=0, state IDLE. Table RAM is not cleared.
- Reset mid-operation aborts the frame at the next edge. The aborted frame is never resumed.
- States: IDLE, LOAD, SHIFT, GAP, DONE.
- IDLE/DONE priority: start beats wr_req.
  - start: state=LOAD, mode=SEQ, word_idx=0, done cleared.
  - wr_req (and no start): state=LOAD, mode=SINGLE.
- LOAD (1 cycle, cs_n high): latch table[word_idx] (SEQ) or wr_data (SINGLE) into the shift register. Next state SHIFT.
- SHIFT (WORD_W*CLK_DIV cycles, cs_n low):
  - mosi holds bit WORD_W-1-b for CLK_DIV cycles.
  - sclk is low for the first CLK_DIV/2 cycles and high for the second half.
  - mosi changes only while sclk is low.
  - After the last bit: sclk=0, next state GAP.
- GAP (CS_GAP cycles, cs_n high, mosi=0):
  - SEQ, more words remain: word_idx+1, go to LOAD.
  - SEQ, last word: go to DONE, done=1.
  - SINGLE: wr_ack pulses on the GAP→exit edge; return to the state it was entered from (IDLE or DONE). done is unchanged.
- Per-word cost is 1 + WORD_W*CLK_DIV + CS_GAP cycles (51 at defaults).
- Timing: busy rises at the edge after start is sampled. done rises N*(1+WORD_W*CLK_DIV+CS_GAP) cycles later.
- seq_len=0: start goes directly to DONE the next cycle. No CS activity.
- wr_req asserted while a SEQ run is busy stays pending and is serviced from DONE. start asserted while busy is ignored.
- Table writes are accepted in any state. A word already latched in LOAD is unaffected. Writes to later indices take effect for this run.
- enable=0: state, bit/cycle counters, sclk, cs_n and mosi all hold. The SPI bus is simply stretched. start and wr_req are not accepted while enable=0.
- Simultaneous tbl_we and LOAD read of the same address: LOAD gets the old data.

Decomposition:
- Package spi_cfg_pkg:
  - state enum (IDLE, LOAD, SHIFT, GAP, DONE) and mode enum (SEQ, SINGLE);
  - default WORD_W/DEPTH constants;
  - ADRF default init table as a constant array, loaded by the host/bench through tbl_we.
- One sub-module, spi_tx_shifter: WORD_W shift register, CLK_DIV phase counter and bit counter, with load/en inputs and a last_bit output.
- The top level owns the FSM, table RAM, word_idx and the handshake.

Test Plan:
- Defaults; load table[0]=24'h02F67F, [1]=24'h04081A; seq_len=2; pulse start → two CS-low windows of 48 cycles each. Captured words are 0x02F67F, 0x04081A (MSB first, sampled on sclk rise). done rises 102 cycles after busy rises.
- seq_len=0, start → done=1 the next cycle; cs_n never low.
- After DONE, wr_req with wr_data=24'h66141E → one 48-cycle frame, capture 0x66141E. wr_ack is a 1-cycle pulse 51 cycles after LOAD entry; done stays 1.
- enable dropped for 10 cycles mid-SHIFT at bit 7 → sclk/cs_n/mosi frozen 10 cycles. Captured word is unchanged; done is delayed by exactly 10 cycles.
- Reset asserted at bit 12 of word 1 → next edge cs_n=1, sclk=0, mosi=0, busy=0, done=0. A new start replays from word 0.
- tbl_we to entry 1 (0xABCDEF) during word 0 SHIFT → word 1 transmits 0xABCDEF. A wr_req raised during the run is serviced only after done=1.
